// File: rtl/slb_pool_reader_if.sv
// Pixel-stream and pooled-result signals between the SLB, the pooling reader and its consumer.
// The master side drives the pixel stream; the slave side is the pooling reader.
interface slb_pool_reader_if #(
  parameter int DW = 8
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;

  modport master (
    output start, in_valid, in_data,
    input  busy, out_valid, out_data, frame_done
  );

  modport slave (
    input  start, in_valid, in_data,
    output busy, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/slb_pool_reader.sv
// SLB consumer: 2x2 stride-2 max pooling over a raster-order pixel stream, one frame per start pulse.
// Optional macro SLB_POOL_SIGNED_EN switches every max comparison to two's-complement signed.
module slb_pool_reader #(
  parameter int DW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5
) (
  input logic              clk,
  input logic              rst_n,
  slb_pool_reader_if.slave bus
);

  localparam int HALF_W = IMG_W / 2;
  localparam int IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [DW-1:0] pair_q, pair_d;
  logic [DW-1:0] outData_q, outData_d;
  logic          outValid_q, outValid_d;

  logic [DW-1:0] rowBuf [HALF_W];
  logic [IW-1:0] bufIdx;
  logic [DW-1:0] hMax;
  logic          bufWrite;

  function automatic logic [DW-1:0] maxOf(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SLB_POOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  // Each horizontal pair of a row shares one buffer slot, so the slot index is col>>1.
  assign bufIdx = col_q[IW:1];
  assign hMax   = maxOf(pair_q, bus.in_data);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pair_d     = pair_q;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    bufWrite   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          // Even rows park the horizontal max; odd rows close the window against it.
          if (!col_q[0]) begin
            pair_d = bus.in_data;
          end else if (!row_q[0]) begin
            bufWrite = 1'b1;
          end else begin
            outData_d  = maxOf(rowBuf[bufIdx], hMax);
            outValid_d = 1'b1;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pair_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pair_q     <= pair_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  // Buffer contents are only read after being written in the same frame, so no reset.
  always_ff @(posedge clk) begin
    if (bufWrite) begin
      rowBuf[bufIdx] <= hMax;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.frame_done = (state_q == DONE);
  assign bus.out_valid  = outValid_q;
  assign bus.out_data   = outData_q;

endmodule
